// File: rtl/second_max_pkg.sv
// Shared types and helpers for the second-max scheduler slice.
// Holds the FSM state enum, default widths and round-robin search.
package second_max_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;
  localparam int MAX_REQ    = 16;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    RESULT
  } state_e;

  // First set bit of req searching upward from (ptr+1) mod n, with wrap.
  function automatic logic [3:0] next_grant(
    input logic [MAX_REQ-1:0] req,
    input logic [3:0]         ptr,
    input int                 n
  );
    logic [3:0] g;
    int         idx;
    g = ptr;
    for (int k = MAX_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % n;
      if (k <= n && req[idx]) g = 4'(idx);
    end
    return g;
  endfunction

endpackage

// File: rtl/second_max_tracker.sv
// Running max / second-distinct-max tracker with a saturating beat count.
// Cleared at frame start; updated once per accepted beat.
module second_max_tracker
  import second_max_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] max,
  output logic [DATA_W-1:0] second,
  output logic              second_vld,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] sec_q, sec_d;
  logic              vld_q, vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    max_d = max_q;
    sec_d = sec_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (clear) begin
      max_d = '0;
      sec_d = '0;
      vld_d = 1'b0;
      cnt_d = '0;
    end else if (valid) begin
      // Count never wraps, so zero reliably marks the first beat.
      if (cnt_q == '0) begin
        max_d = data;
      end else if (data > max_q) begin
        sec_d = max_q;
        vld_d = 1'b1;
        max_d = data;
      end else if (data < max_q && (!vld_q || data > sec_q)) begin
        sec_d = data;
        vld_d = 1'b1;
      end
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q <= '0;
      sec_q <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      max_q <= max_d;
      sec_q <= sec_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign max        = max_q;
  assign second     = sec_q;
  assign second_vld = vld_q;
  assign count      = cnt_q;

endmodule

// File: rtl/second_max_scheduler.sv
// Frame-based round-robin front end sharing one second-max tracker.
// One requester owns the tracker per frame; result is held until taken.
module second_max_scheduler
  import second_max_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ID_W-1:0]         res_id,
  output logic [DATA_W-1:0]       res_max,
  output logic [DATA_W-1:0]       res_second,
  output logic                    res_second_vld,
  output logic [CNT_W-1:0]        res_count,
  output logic                    busy
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              trk_clear;
  logic              beat;
  logic [DATA_W-1:0] beat_data;
  logic [DATA_W-1:0] trk_max;
  logic [DATA_W-1:0] trk_sec;
  logic              trk_vld;
  logic [CNT_W-1:0]  trk_cnt;

  assign beat_data = req_data[int'(grant_q)*DATA_W +: DATA_W];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    trk_clear = 1'b0;
    beat      = 1'b0;
    req_ready = '0;
    res_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d   = ID_W'(next_grant(16'(req_valid),
                                       4'(ptr_q), N_REQ));
          trk_clear = 1'b1;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        req_ready[grant_q] = 1'b1;
        beat = req_valid[grant_q];
        if (beat && req_last[grant_q]) state_d = RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          ptr_d   = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= ID_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  second_max_tracker #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_trk (
    .clk        (clk),
    .reset      (reset),
    .clear      (trk_clear),
    .valid      (beat),
    .data       (beat_data),
    .max        (trk_max),
    .second     (trk_sec),
    .second_vld (trk_vld),
    .count      (trk_cnt)
  );

  assign res_id         = grant_q;
  assign res_max        = trk_max;
  assign res_second     = trk_vld ? trk_sec : '0;
  assign res_second_vld = trk_vld;
  assign res_count      = trk_cnt;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_second_max_scheduler.sv
// Directed bench for second_max_scheduler: frame table plus
// hand sequences for hold, contention, reset and saturation.
module tb_second_max_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            res_valid;
  logic            res_ready;
  logic [IW-1:0]   res_id;
  logic [DW-1:0]   res_max;
  logic [DW-1:0]   res_second;
  logic            res_second_vld;
  logic [CW-1:0]   res_count;
  logic            busy;

  second_max_scheduler #(
    .N_REQ  (N),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_id         (res_id),
    .res_max        (res_max),
    .res_second     (res_second),
    .res_second_vld (res_second_vld),
    .res_count      (res_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hot_bad = 0;
  logic [7:0] beats [300];

  typedef struct {
    int id;
    int n;
    bit bub;
    logic [7:0][7:0] d;
    int emax;
    int esec;
    int evld;
    int ecnt;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input int id, input int n, input bit bub);
    int i = 0;
    int cyc = 0;
    while (i < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      req_valid[id] = !(bub && cyc[0]);
      req_data[id*DW +: DW] = beats[i];
      req_last[id] = (i == n - 1);
      if (!$onehot0(req_ready)) hot_bad++;
      if (req_ready[id] && req_valid[id]) i++;
    end
    @(negedge clk);
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
    chk("beats_accepted", i, n);
  endtask

  task automatic get_result(input string tag, input int id,
                            input int mx, input int sc,
                            input int vl, input int cn);
    int t = 0;
    while (!res_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_valid"}, res_valid, 1);
    chk({tag, "_id"}, res_id, id);
    chk({tag, "_max"}, res_max, mx);
    chk({tag, "_second"}, res_second, sc);
    chk({tag, "_svld"}, res_second_vld, vl);
    chk({tag, "_count"}, res_count, cn);
    chk({tag, "_busy"}, busy, 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_drop"}, res_valid, 0);
  endtask

  initial begin
    tbl[0] = '{0, 6, 1'b1, {8'd0, 8'd0, 8'd12, 8'd11, 8'd9, 8'd7, 8'd4, 8'd10},
               12, 11, 1, 6};
    tbl[1] = '{1, 3, 1'b0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd5, 8'd5},
               5, 0, 0, 3};
    tbl[2] = '{1, 1, 1'b0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd8},
               8, 0, 0, 1};
    tbl[3] = '{2, 6, 1'b0, {8'd0, 8'd0, 8'd14, 8'd2, 8'd5, 8'd3, 8'd3, 8'd13},
               14, 13, 1, 6};
    tbl[4] = '{3, 4, 1'b1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd0, 8'd0},
               7, 0, 1, 4};
    tbl[5] = '{0, 5, 1'b0, {8'd0, 8'd0, 8'd0, 8'd6, 8'd4, 8'd9, 8'd9, 8'd3},
               9, 6, 1, 5};

    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    res_ready = 1'b0;
    do_reset();

    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_count", res_count, 0);
    chk("rst_max", res_max, 0);

    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < tbl[v].n; b++) beats[b] = tbl[v].d[b];
      send(tbl[v].id, tbl[v].n, tbl[v].bub);
      get_result($sformatf("vec%0d", v), tbl[v].id, tbl[v].emax,
                 tbl[v].esec, tbl[v].evld, tbl[v].ecnt);
    end

    // Result held with res_ready low while another requester waits.
    beats[0] = 13; beats[1] = 3; beats[2] = 3;
    beats[3] = 5;  beats[4] = 2; beats[5] = 14;
    send(2, 6, 1'b0);
    req_valid[0] = 1'b1;
    req_data[0 +: DW] = 8'd77;
    req_last[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_max", res_max, 14);
      chk("hold_second", res_second, 13);
      chk("hold_count", res_count, 6);
      chk("hold_no_grant", req_ready, 0);
    end
    get_result("hold", 2, 14, 13, 1, 6);
    beats[0] = 77;
    send(0, 1, 1'b0);
    get_result("after_hold", 0, 77, 0, 0, 1);

    // Two requesters contending continuously from reset.
    do_reset();
    begin
      int k = 0;
      int exp_id [4] = '{0, 2, 0, 2};
      res_ready = 1'b1;
      req_data[0 +: DW]  = 8'h11;
      req_data[2*DW +: DW] = 8'h22;
      req_last  = 4'b0101;
      req_valid = 4'b0101;
      for (int c = 0; c < 60 && k < 4; c++) begin
        @(negedge clk);
        if (!$onehot0(req_ready)) hot_bad++;
        if (res_valid) begin
          chk("rr_id", res_id, exp_id[k]);
          chk("rr_max", res_max, exp_id[k] == 0 ? 32'h11 : 32'h22);
          k++;
        end
      end
      chk("rr_results", k, 4);
      req_valid = '0;
      req_last  = '0;
      res_ready = 1'b0;
    end

    // Reset in the middle of a frame discards it.
    do_reset();
    begin
      int acc = 0;
      req_valid[3] = 1'b1;
      req_data[3*DW +: DW] = 8'd9;
      for (int c = 0; c < 50 && acc < 3; c++) begin
        @(negedge clk);
        if (req_ready[3] && req_valid[3]) acc++;
      end
      chk("mid_accepted", acc, 3);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_count", res_count, 0);
      chk("mid_rst_max", res_max, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", req_ready, 0);
      chk("mid_rst_valid", res_valid, 0);
      req_valid[3] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_no_result", res_valid, 0);
      beats[0] = 1; beats[1] = 8;
      send(3, 2, 1'b0);
      get_result("resend", 3, 8, 1, 1, 2);
    end

    // Long frame saturates the beat counter.
    for (int b = 0; b < 300; b++) beats[b] = 8'(b % 100);
    beats[5]   = 250;
    beats[299] = 240;
    send(1, 300, 1'b0);
    get_result("sat", 1, 250, 240, 1, 255);

    chk("ready_onehot", hot_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/second_max_scheduler.md
Name: second_max_scheduler

Overview:
- Shares one running max/second-max tracker among N_REQ streaming requesters.
- Frame-based round-robin arbitration: a requester is granted for one whole frame (up to and including the beat with req_last). The tracker is cleared at frame start, and the frame result is returned tagged with the requester id.
- Sits in front of the existing second-highest tracking datapath; each producer gets its own per-frame answer without its own tracker instance.

Parameters:
- N_REQ, 4, number of requester channels (2..16)
- DATA_W, 8, sample width (unsigned)
- CNT_W, 8, width of per-frame accepted-beat counter (saturating)
- ID_W, $clog2(N_REQ), width of requester id

Ports:
- clk  input  1  single clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  N_REQ  per-requester sample valid
- req_data  input  N_REQ*DATA_W  per-requester sample; requester i at bits [i*DATA_W +: DATA_W]
- req_last  input  N_REQ  marks final sample of requester's frame
- req_ready  output  N_REQ  one-hot (or zero) accept for the granted requester
- res_valid  output  1  frame result available
- res_ready  input  1  result consumer accept
- res_id  output  ID_W  requester that produced the result
- res_max  output  DATA_W  largest sample in frame
- res_second  output  DATA_W  largest sample strictly less than res_max; 0 if none
- res_second_vld  output  1  1 when frame held at least two distinct values
- res_count  output  CNT_W  accepted beats in frame, saturates at 2^CNT_W-1
- busy  output  1  high in STREAM or RESULT

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all outputs 0.
  - rr pointer = N_REQ-1, so requester 0 has highest priority first.
  - Tracker regs cleared.
- FSM states: IDLE, STREAM, RESULT.
- IDLE:
  - req_ready=0.
  - If any req_valid, select the first set bit searching from (ptr+1) mod N_REQ upward with wrap; register it as grant.
  - Clear max/second/second_vld/count; next state STREAM.
  - No beat is accepted in the IDLE cycle (1-cycle grant latency).
- STREAM:
  - req_ready[grant]=1, all other bits 0.
  - A beat is accepted when req_valid[grant]=1. Bubbles (valid low) are allowed and do not end the frame.
  - Other requesters' valid is ignored; they hold and wait.
- Update on accepted beat d:
  - d>max: second<=max, second_vld<=(count!=0), max<=d.
  - d==max: no change to max/second (duplicates not distinct). If count==0, max<=d.
  - d<max and (!second_vld or d>second): second<=d, second_vld<=1.
  - count<=count+1, saturating.
  - The first beat of a frame always loads max<=d.
- Accepted beat with req_last[grant]=1: the beat is included in the result; next state RESULT. Single-beat frames are legal.
- RESULT:
  - req_ready=0; res_valid=1; res_* hold stable.
  - res_id=grant; res_second=0 when !second_vld.
  - On res_ready=1: ptr<=grant, go to IDLE, res_valid drops next cycle.
  - res_valid never de-asserts without res_ready.
- Round-robin: after serving i, search starts at i+1. A requester continuously valid cannot be starved; the worst-case wait is N_REQ-1 frames.
- Simultaneous events:
  - A new req_valid during STREAM/RESULT is only considered in IDLE.
  - req_last without req_valid has no effect.
- Reset mid-frame: the frame is discarded and no result is produced; the requester must resend the whole frame.
- Arithmetic: unsigned compare only; no overflow paths except count saturation.

Decomposition:
- Package second_max_pkg: state enum (IDLE, STREAM, RESULT); default widths DATA_W=8, CNT_W=8; round-robin search function next_grant(req, ptr).
- Sub-module second_max_tracker:
  - Inputs: clk, reset, clear, valid, data.
  - Outputs: max, second, second_vld, count.
  - Holds all compare/update logic.
- The scheduler holds the FSM, arbitration, muxing and result hold.

Test Plan:
- Req0 only; frame 10,4,7,9,11,12(last), with bubbles between beats -> res_id=0, max=12, second=11, second_vld=1, count=6.
- Req1 frame 5,5,5(last) -> max=5, second=0, second_vld=0, count=3; then single-beat frame 8(last) -> max=8, second_vld=0, count=1.
- Req0 and req2 valid at the same time continuously after reset -> grant order 0,2,0,2; req_ready never two-hot; a waiting requester's data is untouched until granted.
- Frame 13,3,3,5,2,14(last) with res_ready held low 5 cycles -> res_valid and outputs stable for all 5 cycles: max=14, second=13, count=6. Next grant only after the res_ready handshake.
- Reset asserted after 3 accepted beats of req3 -> all outputs 0 immediately, no result emitted. After release, req3 resends 1,8(last) -> max=8, second=1.
- 300-beat frame -> res_count=255 (saturated), max/second correct.
